// File: rtl/pong_pkg.sv
// Shared constants, state encoding and small helpers for the pong game controller.
package pong_pkg;

  localparam logic [5:0] GRID_W   = 6'd40;
  localparam logic [5:0] GRID_H   = 6'd30;
  localparam logic [5:0] CENTRE_X = 6'd19;
  localparam logic [5:0] CENTRE_Y = 6'd14;
  localparam logic [5:0] LPAD_COL = 6'd1;
  localparam logic [5:0] RPAD_COL = 6'd38;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

  // True when row lies inside the paddle span [top, top+len-1].
  function automatic logic in_span(input logic [5:0] row, input logic [5:0] top,
                                   input logic [5:0] len);
    return (row >= top) && (row < top + len);
  endfunction

  // One paddle move: up decrements, dn increments, both or neither holds; clamped.
  function automatic logic [5:0] pad_move(input logic [5:0] top, input logic up,
                                          input logic dn, input logic [5:0] max_top);
    if (up && !dn && (top != 6'd0)) begin
      return top - 6'd1;
    end else if (dn && !up && (top < max_top)) begin
      return top + 6'd1;
    end else begin
      return top;
    end
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong controller and the display/input top level.
interface pong_game_ctrl_if;
  logic       vsync;
  logic       start;
  logic       p1_up;
  logic       p1_dn;
  logic       p2_up;
  logic       p2_dn;
  logic [9:0] tile_x;
  logic [9:0] tile_y;
  logic       ball_on;
  logic       paddle_on;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [2:0] game_state;
  logic       game_over;

  modport slave (
    input  vsync, start, p1_up, p1_dn, p2_up, p2_dn, tile_x, tile_y,
    output ball_on, paddle_on, score_l, score_r, game_state, game_over
  );

  modport master (
    output vsync, start, p1_up, p1_dn, p2_up, p2_dn, tile_x, tile_y,
    input  ball_on, paddle_on, score_l, score_r, game_state, game_over
  );
endinterface

// File: rtl/pong_frame_tick.sv
// Vsync falling-edge detector plus a frame divider that strobes every DIV-th counted tick.
module pong_frame_tick #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_vsync,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick,
  output logic o_step
);
  localparam logic [3:0] LAST = 4'(DIV - 1);

  logic       r_vsync_q;
  logic [3:0] r_cnt;
  logic       w_tick;

  assign w_tick = r_vsync_q & ~i_vsync;
  assign o_tick = w_tick;
  assign o_step = w_tick & i_en & ~i_clr & (r_cnt == LAST);

  // Delay vsync for edge detection and count enabled ticks, wrapping at DIV.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vsync_q <= 1'b1;
      r_cnt     <= 4'd0;
    end else begin
      r_vsync_q <= i_vsync;
      if (i_clr) begin
        r_cnt <= 4'd0;
      end else if (w_tick && i_en) begin
        r_cnt <= (r_cnt == LAST) ? 4'd0 : r_cnt + 4'd1;
      end
    end
  end
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball/paddle motion, scoring, game FSM and registered pixel flags.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALL_DIV     = 4,
  parameter int PADDLE_DIV   = 2,
  parameter int PADDLE_LEN   = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic            i_clk,
  input  logic            i_reset,
  pong_game_ctrl_if.slave bus
);
  localparam logic [5:0] PLEN       = 6'(PADDLE_LEN);
  localparam logic [5:0] PAD_MAX    = GRID_H - PLEN;
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

  game_state_t r_state, w_next;
  logic [5:0]  r_bx, r_by, r_lpad, r_rpad;
  logic        r_dx_neg, r_dy_neg;
  logic [3:0]  r_score_l, r_score_r;
  logic [7:0]  r_serve_cnt;
  logic        r_ball_on, r_paddle_on, r_game_over;

  logic        w_tick_ball, w_tick_pad, w_tick;
  logic        w_ball_step, w_pad_step, w_new_game;
  logic [5:0]  w_bx_nxt, w_by_nxt;
  logic        w_dx_neg_nxt, w_dy_neg_nxt;
  logic        w_in_grid, w_ball_hit, w_pad_hit;

  // Ball divider only counts while playing; held clear otherwise so it restarts on entry.
  pong_frame_tick #(.DIV(BALL_DIV)) u_ball_tick (
    .i_clk(i_clk), .i_reset(i_reset), .i_vsync(bus.vsync),
    .i_en(r_state == ST_PLAY), .i_clr(r_state != ST_PLAY),
    .o_tick(w_tick_ball), .o_step(w_ball_step)
  );

  pong_frame_tick #(.DIV(PADDLE_DIV)) u_pad_tick (
    .i_clk(i_clk), .i_reset(i_reset), .i_vsync(bus.vsync),
    .i_en((r_state == ST_SERVE) || (r_state == ST_PLAY)), .i_clr(1'b0),
    .o_tick(w_tick_pad), .o_step(w_pad_step)
  );

  // Both detectors watch the same vsync, so either one is a valid frame tick.
  assign w_tick     = w_tick_ball | w_tick_pad;
  assign w_new_game = ((r_state == ST_IDLE) || (r_state == ST_GAME_OVER)) && bus.start;

  // Candidate ball position/direction for the next step, walls and paddles reflecting independently.
  always_comb begin
    w_by_nxt     = r_by;
    w_dy_neg_nxt = r_dy_neg;
    w_bx_nxt     = r_bx;
    w_dx_neg_nxt = r_dx_neg;
    if ((r_by == 6'd0) && r_dy_neg) begin
      w_dy_neg_nxt = 1'b0;
      w_by_nxt     = 6'd1;
    end else if ((r_by == GRID_H - 6'd1) && !r_dy_neg) begin
      w_dy_neg_nxt = 1'b1;
      w_by_nxt     = GRID_H - 6'd2;
    end else if (r_dy_neg) begin
      w_by_nxt = r_by - 6'd1;
    end else begin
      w_by_nxt = r_by + 6'd1;
    end
    if ((r_bx == LPAD_COL + 6'd1) && r_dx_neg && in_span(r_by, r_lpad, PLEN)) begin
      w_dx_neg_nxt = 1'b0;
      w_bx_nxt     = LPAD_COL + 6'd2;
    end else if ((r_bx == RPAD_COL - 6'd1) && !r_dx_neg && in_span(r_by, r_rpad, PLEN)) begin
      w_dx_neg_nxt = 1'b1;
      w_bx_nxt     = RPAD_COL - 6'd2;
    end else if (r_dx_neg) begin
      w_bx_nxt = r_bx - 6'd1;
    end else begin
      w_bx_nxt = r_bx + 6'd1;
    end
  end

  // Game FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next = ST_SERVE;
        else           w_next = ST_IDLE;
      end
      ST_SERVE: begin
        if (w_tick && (r_serve_cnt == SERVE_LAST)) w_next = ST_PLAY;
        else                                       w_next = ST_SERVE;
      end
      ST_PLAY: begin
        if (w_ball_step && ((w_bx_nxt == 6'd0) || (w_bx_nxt == GRID_W - 6'd1))) w_next = ST_POINT;
        else                                                                   w_next = ST_PLAY;
      end
      ST_POINT: begin
        if ((r_score_l == WIN) || (r_score_r == WIN)) w_next = ST_GAME_OVER;
        else                                          w_next = ST_SERVE;
      end
      ST_GAME_OVER: begin
        if (bus.start) w_next = ST_SERVE;
        else           w_next = ST_GAME_OVER;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register and its game-over flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_game_over <= (w_next == ST_GAME_OVER);
    end
  end

  // Ball, scores, paddles and serve-delay counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bx        <= CENTRE_X;
      r_by        <= CENTRE_Y;
      r_dx_neg    <= 1'b0;
      r_dy_neg    <= 1'b0;
      r_score_l   <= 4'd0;
      r_score_r   <= 4'd0;
      r_lpad      <= 6'd13;
      r_rpad      <= 6'd13;
      r_serve_cnt <= 8'd0;
    end else begin
      if (w_new_game) begin
        r_score_l <= 4'd0;
        r_score_r <= 4'd0;
        r_bx      <= CENTRE_X;
        r_by      <= CENTRE_Y;
        if (r_state == ST_GAME_OVER) r_dx_neg <= 1'b0;
      end else if (w_ball_step) begin
        r_bx     <= w_bx_nxt;
        r_by     <= w_by_nxt;
        r_dx_neg <= w_dx_neg_nxt;
        r_dy_neg <= w_dy_neg_nxt;
        if ((w_bx_nxt == 6'd0) && (r_score_r < WIN)) r_score_r <= r_score_r + 4'd1;
        if ((w_bx_nxt == GRID_W - 6'd1) && (r_score_l < WIN)) r_score_l <= r_score_l + 4'd1;
      end else if ((r_state == ST_POINT) && (w_next == ST_SERVE)) begin
        // Serve toward the player who just lost the point.
        r_bx     <= CENTRE_X;
        r_by     <= CENTRE_Y;
        r_dx_neg <= (r_bx == 6'd0);
        r_dy_neg <= 1'b0;
      end
      if (w_pad_step) begin
        r_lpad <= pad_move(r_lpad, bus.p1_up, bus.p1_dn, PAD_MAX);
        r_rpad <= pad_move(r_rpad, bus.p2_up, bus.p2_dn, PAD_MAX);
      end
      if (r_state != ST_SERVE) r_serve_cnt <= 8'd0;
      else if (w_tick)         r_serve_cnt <= r_serve_cnt + 8'd1;
    end
  end

  assign w_in_grid  = (bus.tile_x < {4'd0, GRID_W}) && (bus.tile_y < {4'd0, GRID_H});
  assign w_ball_hit = w_in_grid && (r_state != ST_IDLE) &&
                      (bus.tile_x == {4'd0, r_bx}) && (bus.tile_y == {4'd0, r_by});
  assign w_pad_hit  = w_in_grid &&
                      (((bus.tile_x == {4'd0, LPAD_COL}) && in_span(bus.tile_y[5:0], r_lpad, PLEN)) ||
                       ((bus.tile_x == {4'd0, RPAD_COL}) && in_span(bus.tile_y[5:0], r_rpad, PLEN)));

  // Pixel flags registered one cycle behind the tile coordinates.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ball_on   <= 1'b0;
      r_paddle_on <= 1'b0;
    end else begin
      r_ball_on   <= w_ball_hit;
      r_paddle_on <= w_pad_hit;
    end
  end

  assign bus.ball_on    = r_ball_on;
  assign bus.paddle_on  = r_paddle_on;
  assign bus.score_l    = r_score_l;
  assign bus.score_r    = r_score_r;
  assign bus.game_state = r_state;
  assign bus.game_over  = r_game_over;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table, directed sequences and a model-checked game.
module tb_pong_game_ctrl;
  localparam int BALL_DIV = 4, PADDLE_DIV = 2, PADDLE_LEN = 4, SERVE_FRAMES = 60, WIN_SCORE = 9;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_game_ctrl_if bus();

  pong_game_ctrl #(
    .BALL_DIV(BALL_DIV), .PADDLE_DIV(PADDLE_DIV), .PADDLE_LEN(PADDLE_LEN),
    .SERVE_FRAMES(SERVE_FRAMES), .WIN_SCORE(WIN_SCORE)
  ) dut (
    .i_clk(clk), .i_reset(reset), .bus(bus)
  );

  typedef struct {
    bit         serve;
    logic [9:0] tx;
    logic [9:0] ty;
    bit         eb;
    bit         ep;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural game model
  int mst, mbx, mby, mdx, mdy, mlt, mrt, msl, msr, pad_cnt, ball_cnt, serve_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp_top(input int t);
    if (t < 0) return 0;
    if (t > 30 - PADDLE_LEN) return 30 - PADDLE_LEN;
    return t;
  endfunction

  function automatic bit covers(input int top, input int row);
    return (row >= top) && (row <= top + PADDLE_LEN - 1);
  endfunction

  function automatic bit exp_ball(input int tx, input int ty);
    return (mst != S_IDLE) && (tx == mbx) && (ty == mby);
  endfunction

  function automatic bit exp_pad(input int tx, input int ty);
    return ((tx == 1) && covers(mlt, ty)) || ((tx == 38) && covers(mrt, ty));
  endfunction

  task automatic m_reset();
    mst = S_IDLE; msl = 0; msr = 0; mbx = 19; mby = 14; mdx = 1; mdy = 1;
    mlt = 13; mrt = 13; pad_cnt = 0; ball_cnt = 0; serve_cnt = 0;
  endtask

  task automatic m_start();
    if ((mst == S_IDLE) || (mst == S_OVER)) begin
      if (mst == S_OVER) mdx = 1;
      mst = S_SERVE; msl = 0; msr = 0; mbx = 19; mby = 14; serve_cnt = 0;
    end
  endtask

  task automatic m_ball_step(input int olt, input int ort);
    int nbx, nby;
    nby = mby + mdy;
    if ((nby < 0) || (nby > 29)) begin
      mdy = -mdy;
      nby = mby + mdy;
    end
    nbx = mbx + mdx;
    if ((mdx < 0) && (nbx == 1) && covers(olt, mby)) begin
      mdx = 1; nbx = 3;
    end else if ((mdx > 0) && (nbx == 38) && covers(ort, mby)) begin
      mdx = -1; nbx = 36;
    end
    mbx = nbx; mby = nby;
  endtask

  task automatic m_tick(input bit u1, input bit d1, input bit u2, input bit d2);
    int olt, ort;
    olt = mlt; ort = mrt;
    if ((mst == S_SERVE) || (mst == S_PLAY)) begin
      pad_cnt++;
      if (pad_cnt == PADDLE_DIV) begin
        pad_cnt = 0;
        mlt = clamp_top(mlt + int'(d1) - int'(u1));
        mrt = clamp_top(mrt + int'(d2) - int'(u2));
      end
    end
    if (mst == S_SERVE) begin
      serve_cnt++;
      if (serve_cnt == SERVE_FRAMES) begin mst = S_PLAY; ball_cnt = 0; end
    end else if (mst == S_PLAY) begin
      ball_cnt++;
      if (ball_cnt == BALL_DIV) begin
        ball_cnt = 0;
        m_ball_step(olt, ort);
        if (mbx == 0) begin
          if (msr < WIN_SCORE) msr++;
          mst = S_POINT;
        end else if (mbx == 39) begin
          if (msl < WIN_SCORE) msl++;
          mst = S_POINT;
        end
      end
    end
    if (mst == S_POINT) begin
      if ((msl == WIN_SCORE) || (msr == WIN_SCORE)) begin
        mst = S_OVER;
      end else begin
        mdx = (mbx == 0) ? -1 : 1; mdy = 1; mbx = 19; mby = 14;
        mst = S_SERVE; serve_cnt = 0;
      end
    end
  endtask

  // All driving happens at negedges; the caller is positioned at a negedge.
  task automatic frame(input bit u1, input bit d1, input bit u2, input bit d2, input bit st);
    int w;
    w = int'($urandom_range(3, 1));
    bus.p1_up = u1; bus.p1_dn = d1; bus.p2_up = u2; bus.p2_dn = d2;
    bus.start = st; bus.vsync = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (w - 1) @(negedge clk);
    bus.vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_tick(u1, d1, u2, d2);
  endtask

  task automatic press_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    m_start();
  endtask

  task automatic probe_exp(input int tx, input int ty, input bit eb, input bit ep, input string tag);
    bus.tile_x = 10'(tx); bus.tile_y = 10'(ty);
    @(negedge clk);
    chk({tag, " ball_on"}, int'(bus.ball_on), int'(eb));
    chk({tag, " paddle_on"}, int'(bus.paddle_on), int'(ep));
  endtask

  task automatic probe_model(input int tx, input int ty, input string tag);
    probe_exp(tx, ty, exp_ball(tx, ty), exp_pad(tx, ty), tag);
  endtask

  task automatic check_state(input string tag);
    chk({tag, " game_state"}, int'(bus.game_state), mst);
    chk({tag, " score_l"}, int'(bus.score_l), msl);
    chk({tag, " score_r"}, int'(bus.score_r), msr);
    chk({tag, " game_over"}, int'(bus.game_over), int'(mst == S_OVER));
  endtask

  task automatic track(input int top, input int by, output bit up, output bit dn);
    up = (by < top + 1);
    dn = (by > top + PADDLE_LEN - 2);
  endtask

  initial begin
    #990000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[15];
    bit u1, d1, u2, d2, st;
    int frames;

    vt[0]  = '{1'b0, 10'd1,  10'd13,  1'b0, 1'b1};
    vt[1]  = '{1'b0, 10'd1,  10'd16,  1'b0, 1'b1};
    vt[2]  = '{1'b0, 10'd1,  10'd12,  1'b0, 1'b0};
    vt[3]  = '{1'b0, 10'd1,  10'd17,  1'b0, 1'b0};
    vt[4]  = '{1'b0, 10'd38, 10'd13,  1'b0, 1'b1};
    vt[5]  = '{1'b0, 10'd38, 10'd16,  1'b0, 1'b1};
    vt[6]  = '{1'b0, 10'd38, 10'd17,  1'b0, 1'b0};
    vt[7]  = '{1'b0, 10'd19, 10'd14,  1'b0, 1'b0};
    vt[8]  = '{1'b0, 10'd1,  10'd77,  1'b0, 1'b0};
    vt[9]  = '{1'b1, 10'd19, 10'd14,  1'b1, 1'b0};
    vt[10] = '{1'b1, 10'd20, 10'd14,  1'b0, 1'b0};
    vt[11] = '{1'b1, 10'd19, 10'd15,  1'b0, 1'b0};
    vt[12] = '{1'b1, 10'd83, 10'd14,  1'b0, 1'b0};
    vt[13] = '{1'b1, 10'd19, 10'd526, 1'b0, 1'b0};
    vt[14] = '{1'b1, 10'd1,  10'd14,  1'b0, 1'b1};

    reset = 1'b1; bus.vsync = 1'b1; bus.start = 1'b0;
    bus.p1_up = 1'b0; bus.p1_dn = 1'b0; bus.p2_up = 1'b0; bus.p2_dn = 1'b0;
    bus.tile_x = 10'd1; bus.tile_y = 10'd13;
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset ball_on", int'(bus.ball_on), 0);
    chk("reset paddle_on", int'(bus.paddle_on), 0);
    reset = 1'b0;
    @(negedge clk);
    check_state("after reset");

    // Pixel vector table: IDLE entries first, then SERVE entries after a start pulse.
    for (int i = 0; i < 15; i++) begin
      if (vt[i].serve && (mst == S_IDLE)) begin
        press_start();
        chk("start -> SERVE", int'(bus.game_state), 1);
      end
      probe_exp(int'(vt[i].tx), int'(vt[i].ty), vt[i].eb, vt[i].ep, $sformatf("vec%0d", i));
    end

    // Serve window: paddles to their limits, then both-buttons hold, then SERVE -> PLAY.
    for (int i = 0; i < 60; i++) begin
      u1 = (i < 50); d1 = (i >= 40) && (i < 50);
      u2 = (i >= 40) && (i < 50); d2 = (i < 50);
      frame(u1, d1, u2, d2, 1'b0);
      check_state("serve");
      if ((i == 39) || (i == 49)) begin
        probe_exp(1, 0, 1'b0, 1'b1, "lpad top clamp");
        probe_exp(1, 3, 1'b0, 1'b1, "lpad bottom");
        probe_exp(1, 4, 1'b0, 1'b0, "lpad below");
        probe_exp(38, 26, 1'b0, 1'b1, "rpad top");
        probe_exp(38, 25, 1'b0, 1'b0, "rpad above");
        probe_exp(38, 29, 1'b0, 1'b1, "rpad bottom clamp");
      end
      if (i == 58) chk("still SERVE at 59 ticks", int'(bus.game_state), 1);
      if (i == 59) chk("PLAY at 60 ticks", int'(bus.game_state), 2);
    end
    probe_exp(19, 14, 1'b1, 1'b0, "ball held at serve");
    for (int i = 0; i < 4; i++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_state("first step");
      if (i == 2) probe_exp(19, 14, 1'b1, 1'b0, "ball before 4th tick");
    end
    probe_exp(20, 15, 1'b1, 1'b0, "ball first step");
    probe_exp(19, 14, 1'b0, 1'b0, "ball left centre");

    // Model-checked game: right perfect and left idle until two right points, then the reverse.
    frames = 0;
    while ((mst != S_OVER) && (frames < 7000)) begin
      if (msr < 2) begin
        u1 = 1'b0; d1 = 1'b0;
        track(mrt, mby, u2, d2);
      end else begin
        track(mlt, mby, u1, d1);
        if ($urandom_range(99, 0) < 20) track(mrt, mby, u2, d2);
        else begin u2 = 1'b0; d2 = 1'b0; end
      end
      st = ((mst == S_SERVE) || (mst == S_PLAY)) && ($urandom_range(9, 0) == 0);
      frame(u1, d1, u2, d2, st);
      check_state("game");
      probe_model(mbx, mby, "game ball");
      probe_model(1, mlt + PADDLE_LEN - 1, "game lpad");
      probe_model(38, mrt + PADDLE_LEN, "game rpad edge");
      frames++;
    end
    chk("game over flag", int'(bus.game_over), 1);
    chk("final score_l", int'(bus.score_l), WIN_SCORE);
    chk("final score_r", int'(bus.score_r), 2);

    // Frozen in GAME_OVER regardless of buttons.
    for (int i = 0; i < 5; i++) begin
      frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      check_state("frozen");
      chk("frozen state", int'(bus.game_state), 4);
      probe_model(mbx, mby, "frozen ball");
    end

    press_start();
    chk("restart state", int'(bus.game_state), 1);
    chk("restart score_l", int'(bus.score_l), 0);
    probe_exp(19, 14, 1'b1, exp_pad(19, 14), "restart ball");
    for (int i = 0; i < 66; i++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_state("replay");
      probe_model(mbx, mby, "replay ball");
    end
    chk("replay in PLAY", int'(bus.game_state), 2);

    // Reset in the middle of PLAY, with the tile sitting on the ball.
    bus.tile_x = 10'(mbx); bus.tile_y = 10'(mby);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid reset state", int'(bus.game_state), 0);
    chk("mid reset score_l", int'(bus.score_l), 0);
    chk("mid reset score_r", int'(bus.score_r), 0);
    chk("mid reset game_over", int'(bus.game_over), 0);
    chk("mid reset ball_on", int'(bus.ball_on), 0);
    reset = 1'b0;
    m_reset();
    probe_exp(1, 13, 1'b0, 1'b1, "post reset lpad");
    probe_exp(38, 16, 1'b0, 1'b1, "post reset rpad");
    probe_exp(19, 14, 1'b0, 1'b0, "post reset idle ball");
    press_start();
    probe_exp(19, 14, 1'b1, 1'b0, "post reset serve ball");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller for the tile-based pong display on the 40x30 grid (pixel counters >>4).
- Owns ball position, ball direction, both paddle positions, scores and the game state machine.
- Advances the game once per frame, using a Vsync edge as the frame tick.
- Generates registered ball_on / paddle_on pixel flags that the top level maps to rgb_colour.

Parameters:
BALL_DIV, 4, frames per ball step (1..15)
PADDLE_DIV, 2, frames per paddle step (1..15)
PADDLE_LEN, 4, paddle height in tiles (2..8)
SERVE_FRAMES, 60, frames spent in SERVE before PLAY
WIN_SCORE, 9, points that end the game (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vsync  in  1  VGA Vsync, active-low pulse
start  in  1  level; begins or restarts a game
p1_up, p1_dn  in  1 each  left paddle buttons (pre-debounced)
p2_up, p2_dn  in  1 each  right paddle buttons (pre-debounced)
tile_x  in  10  horizontal tile index (hori_cnt>>4)
tile_y  in  10  vertical tile index (vert_cnt>>4)
ball_on  out  1  current tile is the ball
paddle_on  out  1  current tile is a paddle
score_l, score_r  out  4 each  scores
game_state  out  3  encoded FSM state
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset values (synchronous, any cycle, including mid-frame or mid-game):
  - state IDLE; scores 0; ball (19,14); dx=+1, dy=+1.
  - Both paddle tops = 13; all divider counters 0; ball_on = paddle_on = 0; vsync_q = 1.
- Frame tick:
  - tick = vsync_q & ~vsync, where vsync_q is vsync registered one cycle.
  - tick is one cycle wide; all game updates occur only in tick cycles.
- Paddles:
  - Left paddle at column 1, right paddle at column 38, rows [top, top+PADDLE_LEN-1].
  - Paddles move only in SERVE and PLAY, on every PADDLE_DIV-th tick.
  - up decrements top, dn increments top; up and dn together means no move.
  - top is clamped to 0 .. 30-PADDLE_LEN.
- Ball steps on every BALL_DIV-th tick, in PLAY only. The ball divider counter clears on entering PLAY.
- Step rules, evaluated from the current position and direction:
  - Vertical: if by==0 and dy=-1, or by==29 and dy=+1, flip dy and move one row the new way. Otherwise by += dy.
  - Horizontal paddle hit: if bx==2, dx=-1 and the left paddle covers by (pre-step row), set dx=+1 and bx=3. Mirror this at bx==37 against the right paddle (dx=-1, bx=36).
  - Otherwise bx += dx.
  - Vertical and horizontal reflections are independent; a corner reflects both in the same step.
- FSM:
  - IDLE -> SERVE when start=1 (sampled any cycle). Scores are cleared on this transition.
  - SERVE: ball held at (19,14). After SERVE_FRAMES ticks -> PLAY.
  - PLAY: when a step makes bx==0, score_r++ and go to POINT. When bx==39, score_l++ and go to POINT.
  - POINT (one cycle):
    - If the incremented score equals WIN_SCORE -> GAME_OVER.
    - Else -> SERVE, with ball recentred, dx toward the player who lost the point, and dy=+1.
  - GAME_OVER: everything frozen and game_over=1. start=1 -> SERVE with scores cleared and dx=+1.
  - State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4.
- Score saturates at WIN_SCORE and never wraps.
- Pixel flags:
  - Registered, 1-cycle latency from tile_x/tile_y.
  - ball_on = (tile_x==bx && tile_y==by), and is forced 0 in IDLE.
  - paddle_on is true at column 1 or 38 with tile_y inside that paddle's span.
  - Tiles with tile_x>=40 or tile_y>=30 give 0 for both flags.

Decomposition:
- Shared package pong_pkg holds:
  - GRID_W=40, GRID_H=30, CENTRE_X=19, CENTRE_Y=14, LPAD_COL=1, RPAD_COL=38.
  - game_state_t enum with the encoding above.
- Sub-module pong_frame_tick handles Vsync edge detection and one tick divider instance. It is instantiated twice, once for the ball and once for the paddles.

Test Plan:
- reset, start=1 pulse, 60 vsync falling edges -> game_state 0->1->2; ball at (19,14) until PLAY, then (20,15) after 4 more ticks.
- ball at (2,13), dx=-1, left paddle top=12 -> next step: ball (3,14), dx=+1, scores unchanged.
- ball at (2,20), dx=-1, left paddle top=0 -> steps to (1,21) then (0,22); score_r=1; POINT then SERVE; ball (19,14); dx=-1.
- p1_up held for 40 ticks from top=13 -> top saturates at 0. p1_up and p1_dn together -> top unchanged. p2_dn held -> top stops at 26.
- ball at (37,29), dx=+1, dy=+1, right paddle covering row 29 -> corner bounce to (36,28), dx=-1, dy=-1.
- score_l=8, WIN_SCORE=9, ball reaches x=39 -> score_l=9 and game_over=1. Further ticks change nothing. start=1 -> scores 0 and SERVE. Reset asserted mid-PLAY -> IDLE next cycle with all reset values.
